l2_ram_interleaved_xbar: RTL
============================

// Module: l2_ram_interleaved_xbar
// PURPOSE
//  Parametrised successor to the fixed 4-bank L2 RAM wrapper. NB_PORTS masters share NB_BANKS
//  single-port word banks through a crossbar, using the TCDM-style req/gnt/r_valid protocol.
//  Bank mapping is either word-interleaved or contiguous. Conflicts are resolved by a
//  round-robin arbiter per bank. Sits between the SoC L2 interconnect and the behavioural memory cuts.
// PARAMETERS
//  NB_PORTS     4      number of master ports, >=1
//  NB_BANKS     4      number of banks, power of two, >=2
//  BANK_SIZE    8192   32-bit words per bank, power of two
//  INTERLEAVED  1      1: bank = low word-address bits; 0: bank = bits above row index
// PORTS
//  clk_i      in   1              clock, rising edge
//  rst_i      in   1              synchronous reset, active-high
//  req_i      in   NB_PORTS       per-port request
//  add_i      in   NB_PORTS*32    per-port byte address; port p = [32*p +: 32]
//  wen_i      in   NB_PORTS       1 = read, 0 = write
//  be_i       in   NB_PORTS*4     per-port byte enables (writes only)
//  wdata_i    in   NB_PORTS*32    per-port write data
//  gnt_o      out  NB_PORTS       per-port grant; combinational from req_i
//  r_valid_o  out  NB_PORTS       response strobe, one cycle after the grant
//  r_rdata_o  out  NB_PORTS*32    response data
// BEHAVIOUR
//  Address decode
//   - BW = log2(NB_BANKS); AW = log2(BANK_SIZE); word = add[31:2].
//   - INTERLEAVED=1: bank = word[BW-1:0], row = word[BW +: AW].
//   - INTERLEAVED=0: bank = word[AW +: BW], row = word[AW-1:0].
//   - Bits above BW+AW are ignored, so addresses alias.
//  Arbitration (per bank b)
//   - Candidates: ports with req_i=1 that decode to bank b.
//   - Grant the first candidate at index >= ptr[b], searching cyclically.
//   - On a grant to port g: ptr[b] <= (g+1) mod NB_PORTS. Otherwise ptr[b] holds.
//   - A port decodes to exactly one bank, so it gets at most one grant per cycle.
//   - Requests to distinct banks are all granted in the same cycle.
//   - An ungranted port keeps req_i and address stable until granted. No timeout.
//  Access and response
//   - Granted write: byte k of row written iff be[k]=1. be=0 is granted but is a no-op write.
//   - Granted read: row is read, and the data appears on r_rdata_o[p] at the next edge.
//   - r_valid_o[p] is 1 for exactly one cycle, on the cycle after every grant (reads and writes).
//   - r_rdata_o[p] = 0 on a write response. It holds its last value while r_valid_o=0.
//   - Back-to-back grants to one port give back-to-back r_valid_o pulses. No throughput bubble.
//   - Write then read of the same address on consecutive grants returns the new data.
//   - Within one cycle there is one access per bank, so no read/write hazard exists.
//  Reset (rst_i=1 at a clock edge)
//   - gnt_o = 0 while rst_i=1, forced combinationally.
//   - After the edge: r_valid_o = 0, r_rdata_o = 0, all ptr = 0.
//   - Memory array is not reset. Contents are retained across reset and are X after power-up.
//   - Reset asserted in the cycle after a grant: that response is dropped (r_valid_o=0).
//     A write that was granted before the reset edge has completed.
// TESTING (NB_PORTS=4, NB_BANKS=4, BANK_SIZE=256, INTERLEAVED=1 unless stated)
//  1 rst_i=1 for 2 cycles with all req_i=1
//    -> gnt_o=0 throughout; r_valid_o=0 and r_rdata_o=0 after the first edge.
//  2 p0 writes 0xDEADBEEF to 0x10, be=0xF, then reads 0x10
//    -> decodes to bank0/row1; gnt same cycle; r_valid next cycle; rdata=0xDEADBEEF.
//  3 p1 writes 0x11223344 to 0x10 with be=0x5, then reads
//    -> rdata=0xDE22BE44; a be=0 write leaves the word unchanged but still gets gnt/r_valid.
//  4 p0..p3 all read bank1 (0x04,0x14,0x24,0x34) and hold req_i
//    -> grants p0,p1,p2,p3 on 4 consecutive cycles.
//     p0..p3 reading 0x00,0x04,0x08,0x0C -> all 4 granted in one cycle.
//  5 INTERLEAVED=0: write 0xCAFE0001 to 0x400
//    -> stored in bank1/row0; read of 0x400 returns it; read of 0x1400 (alias) returns it too.
//  6 p2 read granted, then rst_i=1 the next cycle
//    -> r_valid_o[2] stays 0; after reset, p2 read of the same address returns the previously written data.

Source files
------------

// File: rtl/l2_ram_interleaved_xbar.sv
// l2_ram_interleaved_xbar: NB_PORTS masters sharing NB_BANKS single-port word banks via a round-robin crossbar
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   req_i/add_i/wen_i   per-port request, byte address, 1=read/0=write
//   be_i/wdata_i        per-port byte enables and write data
//   gnt_o               per-port grant, combinational from req_i
//   r_valid_o/r_rdata_o per-port response strobe and read data, one cycle after grant
module l2_ram_interleaved_xbar #(
    parameter int NB_PORTS    = 4,
    parameter int NB_BANKS    = 4,
    parameter int BANK_SIZE   = 8192,
    parameter int INTERLEAVED = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NB_PORTS-1:0]      req_i,
    input  logic [NB_PORTS*32-1:0]   add_i,
    input  logic [NB_PORTS-1:0]      wen_i,
    input  logic [NB_PORTS*4-1:0]    be_i,
    input  logic [NB_PORTS*32-1:0]   wdata_i,
    output logic [NB_PORTS-1:0]      gnt_o,
    output logic [NB_PORTS-1:0]      r_valid_o,
    output logic [NB_PORTS*32-1:0]   r_rdata_o
);
    localparam int BW = $clog2(NB_BANKS);
    localparam int AW = $clog2(BANK_SIZE);
    localparam int PW = NB_PORTS > 1 ? $clog2(NB_PORTS) : 1;

    logic [BW-1:0]       bank [NB_PORTS];
    logic [AW-1:0]       row [NB_PORTS];
    logic [NB_PORTS-1:0] gnt;
    logic [PW-1:0]       ptr_q [NB_BANKS];
    logic [PW-1:0]       ptr_d [NB_BANKS];
    logic [NB_PORTS-1:0] r_valid_q;
    logic [31:0]         r_rdata_q [NB_PORTS];
    logic [31:0]         mem_q [NB_BANKS][BANK_SIZE];
    logic                found;
    int                  idx;

    // Address bits above BW+AW are simply dropped, so addresses alias.
    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            bank[p] = INTERLEAVED != 0 ? add_i[32*p+2 +: BW] : add_i[32*p+2+AW +: BW];
            row[p]  = INTERLEAVED != 0 ? add_i[32*p+2+BW +: AW] : add_i[32*p+2 +: AW];
        end
    end

    // Per bank: cyclic search starting at ptr for the first requester mapped to it.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int b = 0; b < NB_BANKS; b++) begin
            ptr_d[b] = ptr_q[b];
            found    = 1'b0;
            for (int i = 0; i < NB_PORTS; i++) begin
                idx = int'(ptr_q[b]) + i;
                if (idx >= NB_PORTS) idx = idx - NB_PORTS;
                if (!found && !rst_i && req_i[idx] && bank[idx] == BW'(b)) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                    ptr_d[b] = PW'(idx == NB_PORTS - 1 ? 0 : idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= '0;
            for (int p = 0; p < NB_PORTS; p++) r_rdata_q[p] <= '0;
            for (int b = 0; b < NB_BANKS; b++) ptr_q[b] <= '0;
        end else begin
            r_valid_q <= gnt;
            for (int b = 0; b < NB_BANKS; b++) ptr_q[b] <= ptr_d[b];
            for (int p = 0; p < NB_PORTS; p++)
                if (gnt[p]) r_rdata_q[p] <= wen_i[p] ? mem_q[bank[p]][row[p]] : 32'h0;
        end
    end

    // At most one grant per bank, so these writes never collide; memory is not reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NB_PORTS; p++)
            for (int k = 0; k < 4; k++)
                if (gnt[p] && !wen_i[p] && be_i[4*p+k])
                    mem_q[bank[p]][row[p]][8*k +: 8] <= wdata_i[32*p+8*k +: 8];
    end

    // A response pending while reset is high is dropped.
    assign gnt_o     = gnt;
    assign r_valid_o = r_valid_q & ~{NB_PORTS{rst_i}};

    always_comb begin
        r_rdata_o = '0;
        for (int p = 0; p < NB_PORTS; p++) r_rdata_o[32*p +: 32] = r_rdata_q[p];
    end
endmodule
